mod_counter_array: RTL and testbench
====================================

# mod_counter_array

Parametrised bank of independent modulo counters with per-channel enable, direction and synchronous load, a one-cycle wrap pulse, and a built-in safety monitor that flags any channel reaching a forbidden value once the block has been reset. It generalises the team's fixed single-channel wrap-at-22 counter to N channels, arbitrary width, arbitrary wrap point and up/down counting. The monitor's sticky flags feed the status register. Its embedded property is the formal-verification target.

## Interface
- `WIDTH`, 32, counter width in bits
- `CHANNELS`, 4, number of independent counters
- `WRAP`, 22, terminal value; legal range 0 .. 2^WIDTH-1
- `FORBID`, 10, value a channel must never hold while armed; `FORBID` > `WRAP` makes the check vacuous
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `en`  in  CHANNELS  per-channel count enable
- `up`  in  CHANNELS  per-channel direction: 1 counts up, 0 counts down
- `load`  in  CHANNELS  per-channel synchronous load strobe
- `load_value`  in  CHANNELS*WIDTH  load data; channel i occupies bits [i*WIDTH +: WIDTH]
- `clear_flags`  in  1  clears all `forbid_hit` bits
- `count`  out  CHANNELS*WIDTH  registered counter values, same packing as `load_value`
- `wrap_pulse`  out  CHANNELS  one-cycle pulse when a channel wraps
- `forbid_hit`  out  CHANNELS  sticky: channel held `FORBID` while armed
- `armed`  out  1  high once the block has seen a clean reset release

## Operation
- Per-channel next-state priority: `load` > `en` > hold.
- Load: the next count is `min(load_value, WRAP)`. Out-of-range values clamp to `WRAP`. No wrap pulse.
- Up count: at `WRAP`, the next value is 0 and the channel wraps. Otherwise it adds 1.
- Down count: at 0, the next value is `WRAP` and the channel wraps. Otherwise it subtracts 1.
- Arithmetic is WIDTH-bit unsigned. The count never exceeds `WRAP`, so no natural overflow occurs.
- `WRAP` = 0: the count stays 0 and every enabled cycle is a wrap.
- `armed`: cleared by reset. Set at the first rising edge with `reset_n` high, then held until the next reset.
- Monitor: at each edge where `armed`=1 and channel count == `FORBID`, set `forbid_hit[i]`.
  - `clear_flags` clears all flags.
  - A set and a clear on the same edge: set wins.
- Embedded property, one per channel: `count[i] != FORBID`, disabled while `!armed || !reset_n`. The property fires when the flag sets.

## Timing
- Reset values, applied asynchronously on `reset_n` falling:
  - `count` = 0 for all channels
  - `wrap_pulse` = 0
  - `forbid_hit` = 0
  - `armed` = 0
- All outputs are registered. No combinational input-to-output path.
- Latency: the effect of `load`/`en` appears on `count` one edge after sampling.
- `wrap_pulse[i]` is high during exactly the cycle in which `count[i]` shows the post-wrap value (0 up, `WRAP` down).
- `forbid_hit` rises one edge after `count` shows `FORBID`, subject to the `armed` condition.
- Reset mid-operation: counts drop to 0 immediately and pending pulses are lost. The monitor is disarmed until the first edge after release. A channel loaded to `FORBID` on that first edge is flagged on the following edge.
- Channels never interact.

## Structure
- Package `mod_counter_pkg` contains:
  - the `count_t` typedef (WIDTH-bit)
  - a direction enum (`DIR_DOWN`=0, `DIR_UP`=1)
  - default `WRAP`/`FORBID` constants
- Sub-module `mod_counter_channel` holds one counter, its wrap logic, its flag and its property. The top instantiates `CHANNELS` copies and owns the single `armed` register.

## Test plan
- Reset, then `en`=1 and `up`=1 on channel 0 → count 0..22; on the 23rd edge count = 0 and `wrap_pulse[0]` = 1 for one cycle. Other channels hold 0.
- Down-count from reset, `en`=1 and `up`=0 → first edge gives count = 22 with `wrap_pulse` = 1, then 21, 20, … with no pulse.
- `load`=1, `en`=1, `load_value`=5 → count 5 next cycle, no pulse. Then `load_value`=30 → count clamps to 22.
- Load 10 on channel 2 after `armed` is set → `forbid_hit[2]` = 1 one edge later and stays high while the count moves on. Then:
  - `clear_flags` pulse → flag 0
  - `clear_flags` on the same edge as a new hit → flag stays 1
- Drive `reset_n` low asynchronously while channel 1 = 15 → `count` = 0 and `armed` = 0 immediately. Then release with `load_value` = 10 on the first edge → no flag on that edge; flag sets on the next edge.
- `CHANNELS`=4, `WIDTH`=8, `WRAP`=3, mixed `en`/`up`/`load` per channel over 50 random cycles → every channel matches an independent reference model, including `wrap_pulse` timing.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared types and default constants for the modulo counter bank.
// Count type, direction encoding, and default wrap/forbid points.
package mod_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 32;
    localparam int unsigned DEFAULT_CHANNELS = 4;
    localparam int unsigned DEFAULT_WRAP     = 22;
    localparam int unsigned DEFAULT_FORBID   = 10;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage

// File: rtl/mod_counter_array_if.sv
// Control/status bundle of the counter bank; channel i of each packed
// vector sits at [i*WIDTH +: WIDTH] or bit [i].
interface mod_counter_array_if
    import mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned CHANNELS = DEFAULT_CHANNELS
);

    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       up;
    logic [CHANNELS-1:0]       load;
    logic [CHANNELS*WIDTH-1:0] load_value;
    logic                      clear_flags;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       wrap_pulse;
    logic [CHANNELS-1:0]       forbid_hit;
    logic                      armed;

    modport master (
        output en, up, load, load_value, clear_flags,
        input  count, wrap_pulse, forbid_hit, armed
    );

    modport slave (
        input  en, up, load, load_value, clear_flags,
        output count, wrap_pulse, forbid_hit, armed
    );

endinterface

// File: rtl/mod_counter_channel.sv
// One modulo counter: load/enable/direction, wrap pulse, and a sticky
// monitor flag raised whenever the count sits on FORBID while armed.
module mod_counter_channel
    import mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned WRAP   = DEFAULT_WRAP,
    parameter int unsigned FORBID = DEFAULT_FORBID
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             armed,
    input  logic             en,
    input  dir_e             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_flag,
    output logic [WIDTH-1:0] count,
    output logic             wrap_pulse,
    output logic             forbid_hit
);

    localparam logic [WIDTH-1:0] WRAP_V      = WIDTH'(WRAP);
    localparam logic [WIDTH-1:0] FORBID_V    = WIDTH'(FORBID);
    // A FORBID above WRAP is unreachable; keep truncation from aliasing it.
    localparam bit               FORBID_LIVE = (FORBID <= WRAP);

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             hit_now;

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = (load_value > WRAP_V) ? WRAP_V : load_value;
        end else if (en) begin
            if (dir == DIR_UP) begin
                if (count == WRAP_V) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    count_nxt = WRAP_V;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
        end
    end

    assign hit_now = FORBID_LIVE && armed && (count == FORBID_V);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
            forbid_hit <= 1'b0;
        end else begin
            count      <= count_nxt;
            wrap_pulse <= wrap_nxt;
            if (hit_now)
                forbid_hit <= 1'b1;
            else if (clear_flag)
                forbid_hit <= 1'b0;
        end
    end

`ifdef FORMAL
    no_forbid_value: assert property (@(posedge clock) disable iff (!armed || !reset_n)
        !(FORBID_LIVE && (count == FORBID_V)));
`endif

endmodule

// File: rtl/mod_counter_array.sv
// Bank of CHANNELS independent modulo counters sharing one armed register
// that qualifies every channel's forbidden-value monitor.
module mod_counter_array
    import mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned CHANNELS = DEFAULT_CHANNELS,
    parameter int unsigned WRAP     = DEFAULT_WRAP,
    parameter int unsigned FORBID   = DEFAULT_FORBID
) (
    input logic                clock,
    input logic                reset_n,
    mod_counter_array_if.slave bus
);

    logic                            armed_q;
    logic [CHANNELS-1:0][WIDTH-1:0]  cnt;
    logic [CHANNELS-1:0]             wrap_v;
    logic [CHANNELS-1:0]             hit_v;

    // Armed from the first clock edge seen with reset released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            armed_q <= 1'b0;
        else
            armed_q <= 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        mod_counter_channel #(
            .WIDTH  (WIDTH),
            .WRAP   (WRAP),
            .FORBID (FORBID)
        ) u_ch (
            .clock      (clock),
            .reset_n    (reset_n),
            .armed      (armed_q),
            .en         (bus.en[i]),
            .dir        (dir_e'(bus.up[i])),
            .load       (bus.load[i]),
            .load_value (bus.load_value[i*WIDTH +: WIDTH]),
            .clear_flag (bus.clear_flags),
            .count      (cnt[i]),
            .wrap_pulse (wrap_v[i]),
            .forbid_hit (hit_v[i])
        );
    end

    assign bus.count      = cnt;
    assign bus.wrap_pulse = wrap_v;
    assign bus.forbid_hit = hit_v;
    assign bus.armed      = armed_q;

endmodule

// File: tb/tb_mod_counter_array.sv
// Bench for mod_counter_array: a default-geometry instance (WRAP 22, FORBID 10)
// and a narrow instance (WIDTH 8, WRAP 3, FORBID 2), both against a reference model.
module tb_mod_counter_array;

    localparam int unsigned NCH      = 4;
    localparam int unsigned WA       = 32;
    localparam int unsigned WRAP_A   = 22;
    localparam int unsigned FORBID_A = 10;
    localparam int unsigned WB       = 8;
    localparam int unsigned WRAP_B   = 3;
    localparam int unsigned FORBID_B = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    mod_counter_array_if #(.WIDTH(WA), .CHANNELS(NCH)) ifa ();
    mod_counter_array_if #(.WIDTH(WB), .CHANNELS(NCH)) ifb ();

    mod_counter_array #(.WIDTH(WA), .CHANNELS(NCH), .WRAP(WRAP_A), .FORBID(FORBID_A)) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifa.slave)
    );

    mod_counter_array #(.WIDTH(WB), .CHANNELS(NCH), .WRAP(WRAP_B), .FORBID(FORBID_B)) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (ifb.slave)
    );

    always #5 clock = ~clock;

    // Stimulus for both instances (index 0 = A, 1 = B) and the model state.
    logic [NCH-1:0] in_en   [2];
    logic [NCH-1:0] in_up   [2];
    logic [NCH-1:0] in_load [2];
    int unsigned    in_lv   [2][NCH];
    bit             in_clr  [2];

    int unsigned    mc   [2][NCH];
    bit             mw   [2][NCH];
    bit             mh   [2][NCH];
    bit             marm [2];

    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] up;
        logic [NCH-1:0] load;
        int unsigned    lv;
        bit             clr;
        int             ch;
        int unsigned    exp_c;
        bit             exp_w;
        bit             exp_h;
    } vec_t;

    vec_t tbl [12];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            marm[d] = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                mc[d][i] = 0;
                mw[d][i] = 1'b0;
                mh[d][i] = 1'b0;
            end
        end
    endfunction

    // Counting modulo (wrap+1); the flag looks at the count held before the edge.
    function automatic void model_step(int d, int unsigned wrap, int unsigned forbid);
        for (int i = 0; i < NCH; i++) begin
            if (marm[d] && mc[d][i] == forbid)
                mh[d][i] = 1'b1;
            else if (in_clr[d])
                mh[d][i] = 1'b0;
            mw[d][i] = 1'b0;
            if (in_load[d][i]) begin
                mc[d][i] = (in_lv[d][i] < wrap) ? in_lv[d][i] : wrap;
            end else if (in_en[d][i]) begin
                if (in_up[d][i]) begin
                    mw[d][i] = (mc[d][i] == wrap);
                    mc[d][i] = (mc[d][i] + 1) % (wrap + 1);
                end else begin
                    mw[d][i] = (mc[d][i] == 0);
                    mc[d][i] = (mc[d][i] + wrap) % (wrap + 1);
                end
            end
        end
        marm[d] = 1'b1;
    endfunction

    function automatic void check_all();
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("a.count[%0d]", i), 64'(ifa.count[i*WA +: WA]), 64'(mc[0][i]));
            chk($sformatf("a.wrap[%0d]", i),  64'(ifa.wrap_pulse[i]),     64'(mw[0][i]));
            chk($sformatf("a.hit[%0d]", i),   64'(ifa.forbid_hit[i]),     64'(mh[0][i]));
            chk($sformatf("b.count[%0d]", i), 64'(ifb.count[i*WB +: WB]), 64'(mc[1][i]));
            chk($sformatf("b.wrap[%0d]", i),  64'(ifb.wrap_pulse[i]),     64'(mw[1][i]));
            chk($sformatf("b.hit[%0d]", i),   64'(ifb.forbid_hit[i]),     64'(mh[1][i]));
        end
        chk("a.armed", 64'(ifa.armed), 64'(marm[0]));
        chk("b.armed", 64'(ifb.armed), 64'(marm[1]));
    endfunction

    task automatic drive();
        for (int i = 0; i < NCH; i++) begin
            ifa.load_value[i*WA +: WA] = WA'(in_lv[0][i]);
            ifb.load_value[i*WB +: WB] = WB'(in_lv[1][i]);
        end
        ifa.en = in_en[0]; ifa.up = in_up[0]; ifa.load = in_load[0]; ifa.clear_flags = in_clr[0];
        ifb.en = in_en[1]; ifb.up = in_up[1]; ifb.load = in_load[1]; ifb.clear_flags = in_clr[1];
    endtask

    task automatic set_a(logic [NCH-1:0] en, logic [NCH-1:0] up, logic [NCH-1:0] load,
                         int unsigned lv, bit clr);
        in_en[0] = en; in_up[0] = up; in_load[0] = load; in_clr[0] = clr;
        for (int i = 0; i < NCH; i++) in_lv[0][i] = lv;
        drive();
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(0, WRAP_A, FORBID_A);
        model_step(1, WRAP_B, FORBID_B);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{4'b0001, 4'b0001, 4'b0001,  5, 1'b0, 0,  5, 1'b0, 1'b0};
        tbl[1]  = '{4'b0000, 4'b0000, 4'b0001, 30, 1'b0, 0, 22, 1'b0, 1'b0};
        tbl[2]  = '{4'b0001, 4'b0001, 4'b0000,  0, 1'b0, 0,  0, 1'b1, 1'b0};
        tbl[3]  = '{4'b0000, 4'b0000, 4'b0000,  0, 1'b0, 0,  0, 1'b0, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, 4'b0100, 10, 1'b0, 2, 10, 1'b0, 1'b0};
        tbl[5]  = '{4'b0100, 4'b0100, 4'b0000,  0, 1'b0, 2, 11, 1'b0, 1'b1};
        tbl[6]  = '{4'b0100, 4'b0100, 4'b0000,  0, 1'b0, 2, 12, 1'b0, 1'b1};
        tbl[7]  = '{4'b0000, 4'b0000, 4'b0000,  0, 1'b1, 2, 12, 1'b0, 1'b0};
        tbl[8]  = '{4'b0000, 4'b0000, 4'b0100, 10, 1'b0, 2, 10, 1'b0, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 4'b0000,  0, 1'b1, 2, 10, 1'b0, 1'b1};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0100,  0, 1'b1, 2,  0, 1'b0, 1'b1};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0000,  0, 1'b1, 2,  0, 1'b0, 1'b0};

        for (int d = 0; d < 2; d++) begin
            in_en[d] = '0; in_up[d] = '0; in_load[d] = '0; in_clr[d] = 1'b0;
            for (int i = 0; i < NCH; i++) in_lv[d][i] = 0;
        end
        drive();
        model_reset();

        // Reset values, then up-count on channel 0 through one wrap.
        #12;
        check_all();
        chk("reset.armed", 64'(ifa.armed), 64'd0);
        reset_n = 1'b1;
        set_a(4'b0001, 4'b0001, 4'b0000, 0, 1'b0);
        for (int k = 1; k <= 23; k++) begin
            tick();
            if (k == 1)  chk("up.armed", 64'(ifa.armed), 64'd1);
            if (k == 22) chk("up.count22", 64'(ifa.count[0 +: WA]), 64'd22);
            if (k == 23) begin
                chk("up.count_wrap", 64'(ifa.count[0 +: WA]), 64'd0);
                chk("up.pulse", 64'(ifa.wrap_pulse[0]), 64'd1);
                chk("up.ch1_hold", 64'(ifa.count[WA +: WA]), 64'd0);
            end
        end
        set_a('0, '0, '0, 0, 1'b0);
        tick();
        chk("up.pulse_end", 64'(ifa.wrap_pulse[0]), 64'd0);
        chk("up.hit0", 64'(ifa.forbid_hit[0]), 64'd1);

        // Down-count from reset on channel 3.
        do_reset();
        set_a(4'b1000, 4'b0000, 4'b0000, 0, 1'b0);
        tick();
        chk("down.first", 64'(ifa.count[3*WA +: WA]), 64'd22);
        chk("down.pulse", 64'(ifa.wrap_pulse[3]), 64'd1);
        tick();
        chk("down.second", 64'(ifa.count[3*WA +: WA]), 64'd21);
        chk("down.nopulse", 64'(ifa.wrap_pulse[3]), 64'd0);
        tick();
        chk("down.third", 64'(ifa.count[3*WA +: WA]), 64'd20);

        // Table: load/clamp, wrap, flag set/sticky/clear, set-beats-clear.
        do_reset();
        set_a('0, '0, '0, 0, 1'b0);
        tick();
        for (int v = 0; v < 12; v++) begin
            set_a(tbl[v].en, tbl[v].up, tbl[v].load, tbl[v].lv, tbl[v].clr);
            tick();
            chk($sformatf("tbl%0d.count", v), 64'(ifa.count[tbl[v].ch*WA +: WA]), 64'(tbl[v].exp_c));
            chk($sformatf("tbl%0d.wrap", v),  64'(ifa.wrap_pulse[tbl[v].ch]),     64'(tbl[v].exp_w));
            chk($sformatf("tbl%0d.hit", v),   64'(ifa.forbid_hit[tbl[v].ch]),     64'(tbl[v].exp_h));
        end

        // Asynchronous reset mid-operation, then load FORBID on the first edge.
        set_a(4'b0000, 4'b0000, 4'b0010, 15, 1'b0);
        tick();
        chk("mid.count15", 64'(ifa.count[WA +: WA]), 64'd15);
        set_a('0, '0, '0, 0, 1'b0);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("mid.count0", 64'(ifa.count[WA +: WA]), 64'd0);
        chk("mid.armed0", 64'(ifa.armed), 64'd0);
        check_all();
        #1;
        reset_n = 1'b1;
        set_a(4'b0000, 4'b0000, 4'b0010, 10, 1'b0);
        tick();
        chk("rel.count10", 64'(ifa.count[WA +: WA]), 64'd10);
        chk("rel.nohit", 64'(ifa.forbid_hit[1]), 64'd0);
        set_a('0, '0, '0, 0, 1'b0);
        tick();
        chk("rel.hit", 64'(ifa.forbid_hit[1]), 64'd1);

        // Random mixed traffic on the narrow instance.
        do_reset();
        for (int k = 0; k < 50; k++) begin
            for (int i = 0; i < NCH; i++) begin
                in_en[1][i]   = 1'($urandom_range(0, 1));
                in_up[1][i]   = 1'($urandom_range(0, 1));
                in_load[1][i] = ($urandom_range(0, 3) == 0);
                in_lv[1][i]   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 5) : $urandom_range(0, 255);
            end
            in_clr[1] = ($urandom_range(0, 7) == 0);
            drive();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
